// File: rtl/alu_mul_sequencer.sv
// Shift-add 32x32 multiplier (low word) that borrows the shared integer ALU
// one step at a time; the core stalls on busy_o while it runs.
module alu_mul_sequencer #(
   parameter int DATA_WIDTH    = 32,
   parameter int CONTROL_WIDTH = 3
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic                     start_i,
   input  logic [DATA_WIDTH-1:0]    mcand_i,
   input  logic [DATA_WIDTH-1:0]    mplier_i,
   output logic                     busy_o,
   output logic                     done_o,
   output logic [DATA_WIDTH-1:0]    product_o,
   output logic                     alu_req_o,
   input  logic                     alu_gnt_i,
   output logic [CONTROL_WIDTH-1:0] alu_ctrl_o,
   output logic [DATA_WIDTH-1:0]    alu_a_o,
   output logic [DATA_WIDTH-1:0]    alu_b_o,
   input  logic [DATA_WIDTH-1:0]    alu_result_i
);

   localparam logic [CONTROL_WIDTH-1:0] CtrlAdd = CONTROL_WIDTH'(0);
   localparam logic [CONTROL_WIDTH-1:0] CtrlShl = CONTROL_WIDTH'(5);
   localparam logic [CONTROL_WIDTH-1:0] CtrlShr = CONTROL_WIDTH'(6);
   localparam logic [DATA_WIDTH-1:0]    One     = DATA_WIDTH'(1);

   typedef enum logic [2:0] {
      StIdle,
      StCheck,
      StAdd,
      StShl,
      StShr,
      StDone
   } state_e;

   state_e                   state_q, state_d;
   logic [DATA_WIDTH-1:0]    acc_q, acc_d;
   logic [DATA_WIDTH-1:0]    mc_q, mc_d;
   logic [DATA_WIDTH-1:0]    mp_q, mp_d;
   logic [DATA_WIDTH-1:0]    product_q, product_d;
   logic                     busy_q, busy_d;
   logic                     done_q, done_d;
   logic                     req_q, req_d;
   logic [CONTROL_WIDTH-1:0] ctrl_q, ctrl_d;
   logic [DATA_WIDTH-1:0]    a_q, a_d;
   logic [DATA_WIDTH-1:0]    b_q, b_d;

   // ALU-facing outputs are registered, so they are loaded for the state being
   // entered; an ungranted cycle keeps every register, freezing the ALU request.
   always_comb begin
      state_d   = state_q;
      acc_d     = acc_q;
      mc_d      = mc_q;
      mp_d      = mp_q;
      product_d = product_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      req_d     = req_q;
      ctrl_d    = ctrl_q;
      a_d       = a_q;
      b_d       = b_q;
      unique case (state_q)
         StIdle: begin
            if (start_i) begin
               mc_d    = mcand_i;
               mp_d    = mplier_i;
               acc_d   = '0;
               busy_d  = 1'b1;
               state_d = StCheck;
            end
         end
         StCheck: begin
            if (mp_q == '0) begin
               product_d = acc_q;
               done_d    = 1'b1;
               state_d   = StDone;
            end else if (mp_q[0]) begin
               req_d   = 1'b1;
               ctrl_d  = CtrlAdd;
               a_d     = acc_q;
               b_d     = mc_q;
               state_d = StAdd;
            end else begin
               req_d   = 1'b1;
               ctrl_d  = CtrlShl;
               a_d     = mc_q;
               b_d     = One;
               state_d = StShl;
            end
         end
         StAdd: begin
            if (alu_gnt_i) begin
               acc_d   = alu_result_i;
               ctrl_d  = CtrlShl;
               a_d     = mc_q;
               b_d     = One;
               state_d = StShl;
            end
         end
         StShl: begin
            if (alu_gnt_i) begin
               mc_d    = alu_result_i;
               ctrl_d  = CtrlShr;
               a_d     = mp_q;
               b_d     = One;
               state_d = StShr;
            end
         end
         StShr: begin
            if (alu_gnt_i) begin
               mp_d    = alu_result_i;
               req_d   = 1'b0;
               ctrl_d  = CtrlAdd;
               a_d     = '0;
               b_d     = '0;
               state_d = StCheck;
            end
         end
         StDone: begin
            busy_d  = 1'b0;
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q   <= StIdle;
         acc_q     <= '0;
         mc_q      <= '0;
         mp_q      <= '0;
         product_q <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         req_q     <= 1'b0;
         ctrl_q    <= '0;
         a_q       <= '0;
         b_q       <= '0;
      end else begin
         state_q   <= state_d;
         acc_q     <= acc_d;
         mc_q      <= mc_d;
         mp_q      <= mp_d;
         product_q <= product_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         req_q     <= req_d;
         ctrl_q    <= ctrl_d;
         a_q       <= a_d;
         b_q       <= b_d;
      end
   end

   assign busy_o     = busy_q;
   assign done_o     = done_q;
   assign product_o  = product_q;
   assign alu_req_o  = req_q;
   assign alu_ctrl_o = ctrl_q;
   assign alu_a_o    = a_q;
   assign alu_b_o    = b_q;

endmodule
